// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: size codes, FSM states and byte-lane masks.
// Also provides a helper that maps a size code to its unshifted byte-enable mask.
package lsu_pkg;

    typedef enum logic [1:0] {
        SZ_WORD = 2'b00,
        SZ_HALF = 2'b01,
        SZ_BYTE = 2'b10,
        SZ_ILL  = 2'b11
    } lsu_size_e;

    typedef enum logic [2:0] {
        IDLE,
        REQ_LO,
        WAIT_LO,
        REQ_HI,
        WAIT_HI,
        RESP
    } lsu_state_e;

    localparam logic [3:0] BE_BYTE = 4'b0001;
    localparam logic [3:0] BE_HALF = 4'b0011;
    localparam logic [3:0] BE_WORD = 4'b1111;

    // Illegal sizes get an empty mask so they can never look like a split access.
    function automatic logic [3:0] size_mask(input logic [1:0] size);
        case (size)
            SZ_WORD: size_mask = BE_WORD;
            SZ_HALF: size_mask = BE_HALF;
            SZ_BYTE: size_mask = BE_BYTE;
            default: size_mask = 4'b0000;
        endcase
    endfunction

endpackage

// File: rtl/lsu_align.sv
// Combinational lane steering: shifts store masks/data into the LO/HI words and
// right-aligns plus extends load data gathered from those two words.
module lsu_align
    import lsu_pkg::*;
(
    input  logic [1:0]  size,
    input  logic        sign,
    input  logic [1:0]  offset,
    input  logic [31:0] wdata,
    input  logic [31:0] lo_rdata,
    input  logic [23:0] hi_rdata,
    output logic [3:0]  be_lo,
    output logic [3:0]  be_hi,
    output logic [31:0] wdata_lo,
    output logic [31:0] wdata_hi,
    output logic        split,
    output logic [31:0] rdata
);

    logic [7:0]  mask_wide;
    logic [63:0] wdata_wide;
    logic [31:0] merged;

    always_comb begin
        mask_wide  = {4'b0000, size_mask(size)} << offset;
        wdata_wide = {32'h0, wdata} << {offset, 3'b000};
        be_lo      = mask_wide[3:0];
        be_hi      = mask_wide[7:4];
        split      = |mask_wide[7:4];
        wdata_lo   = wdata_wide[31:0];
        wdata_hi   = wdata_wide[63:32];

        // The top byte of the HI word can never be part of a legal access.
        case (offset)
            2'd0:    merged = lo_rdata;
            2'd1:    merged = {hi_rdata[7:0],  lo_rdata[31:8]};
            2'd2:    merged = {hi_rdata[15:0], lo_rdata[31:16]};
            default: merged = {hi_rdata[23:0], lo_rdata[31:24]};
        endcase

        case (size)
            SZ_BYTE: rdata = {{24{sign & merged[7]}}, merged[7:0]};
            SZ_HALF: rdata = {{16{sign & merged[15]}}, merged[15:0]};
            default: rdata = merged;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit bridging a byte-addressed core request onto a little-endian word port,
// splitting misaligned accesses into LO/HI word transfers.
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int ADDR_W = 17
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              lsu_valid,
    output logic              lsu_ready,
    input  logic              lsu_write,
    input  logic [1:0]        lsu_size,
    input  logic              lsu_sign,
    input  logic [ADDR_W-1:0] lsu_addr,
    input  logic [31:0]       lsu_wdata,
    output logic              lsu_done,
    output logic              lsu_err,
    output logic [31:0]       lsu_rdata,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [3:0]        mem_be,
    output logic [31:0]       mem_wdata,
    input  logic              mem_gnt,
    input  logic              mem_rvalid,
    input  logic [31:0]       mem_rdata
);

    lsu_state_e        state_q, state_d;
    logic              write_q, write_d;
    logic [1:0]        size_q, size_d;
    logic              sign_q, sign_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [31:0]       wdata_q, wdata_d;
    logic [31:0]       lo_data_q, lo_data_d;
    logic [23:0]       hi_data_q, hi_data_d;

    logic              ready_q, ready_d;
    logic              done_q, done_d;
    logic              err_q, err_d;
    logic [31:0]       rdata_q, rdata_d;
    logic              mem_req_q, mem_req_d;
    logic              mem_we_q, mem_we_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [3:0]        mem_be_q, mem_be_d;
    logic [31:0]       mem_wdata_q, mem_wdata_d;

    logic              accept;
    logic [3:0]        be_lo, be_hi;
    logic [31:0]       wd_lo, wd_hi;
    logic              split;
    logic [31:0]       rdata_al;
    logic [ADDR_W-1:0] lo_word_addr, hi_word_addr;

    // Request fields pass straight through on the accept cycle so the first
    // memory request can be registered in the same edge as the fields.
    always_comb begin
        accept    = (state_q == IDLE) && lsu_valid;
        write_d   = accept ? lsu_write : write_q;
        size_d    = accept ? lsu_size  : size_q;
        sign_d    = accept ? lsu_sign  : sign_q;
        addr_d    = accept ? lsu_addr  : addr_q;
        wdata_d   = accept ? lsu_wdata : wdata_q;
        lo_data_d = lo_data_q;
        hi_data_d = hi_data_q;
        if (state_q == WAIT_LO && mem_rvalid) begin
            lo_data_d = mem_rdata;
        end
        if (state_q == WAIT_HI && mem_rvalid) begin
            hi_data_d = mem_rdata[23:0];
        end
        lo_word_addr = {addr_d[ADDR_W-1:2], 2'b00};
        hi_word_addr = lo_word_addr + ADDR_W'(4);
    end

    lsu_align u_align (
        .size     (size_d),
        .sign     (sign_d),
        .offset   (addr_d[1:0]),
        .wdata    (wdata_d),
        .lo_rdata (lo_data_d),
        .hi_rdata (hi_data_d),
        .be_lo    (be_lo),
        .be_hi    (be_hi),
        .wdata_lo (wd_lo),
        .wdata_hi (wd_hi),
        .split    (split),
        .rdata    (rdata_al)
    );

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (lsu_valid) state_d = (lsu_size == SZ_ILL) ? RESP : REQ_LO;
            REQ_LO:  if (mem_gnt) state_d = !write_q ? WAIT_LO : (split ? REQ_HI : RESP);
            WAIT_LO: if (mem_rvalid) state_d = split ? REQ_HI : RESP;
            REQ_HI:  if (mem_gnt) state_d = write_q ? RESP : WAIT_HI;
            WAIT_HI: if (mem_rvalid) state_d = RESP;
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase

        // Outputs are decoded from the next state so they are registered.
        ready_d     = (state_d == IDLE);
        done_d      = (state_d == RESP);
        err_d       = done_d && (size_d == SZ_ILL);
        rdata_d     = (done_d && !write_d && size_d != SZ_ILL) ? rdata_al : 32'h0;
        mem_req_d   = (state_d == REQ_LO) || (state_d == REQ_HI);
        mem_we_d    = mem_req_d && write_d;
        mem_addr_d  = '0;
        mem_be_d    = 4'b0000;
        mem_wdata_d = 32'h0;
        if (state_d == REQ_LO) begin
            mem_addr_d  = lo_word_addr;
            mem_be_d    = be_lo;
            mem_wdata_d = wd_lo;
        end else if (state_d == REQ_HI) begin
            mem_addr_d  = hi_word_addr;
            mem_be_d    = be_hi;
            mem_wdata_d = wd_hi;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            write_q     <= 1'b0;
            size_q      <= 2'b00;
            sign_q      <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= 32'h0;
            lo_data_q   <= 32'h0;
            hi_data_q   <= 24'h0;
            ready_q     <= 1'b1;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            rdata_q     <= 32'h0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_be_q    <= 4'b0000;
            mem_wdata_q <= 32'h0;
        end else begin
            state_q     <= state_d;
            write_q     <= write_d;
            size_q      <= size_d;
            sign_q      <= sign_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            lo_data_q   <= lo_data_d;
            hi_data_q   <= hi_data_d;
            ready_q     <= ready_d;
            done_q      <= done_d;
            err_q       <= err_d;
            rdata_q     <= rdata_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_be_q    <= mem_be_d;
            mem_wdata_q <= mem_wdata_d;
        end
    end

    assign lsu_ready = ready_q;
    assign lsu_done  = done_q;
    assign lsu_err   = err_q;
    assign lsu_rdata = rdata_q;
    assign mem_req   = mem_req_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_be    = mem_be_q;
    assign mem_wdata = mem_wdata_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit: a vector table drives requests, a scoreboard
// holds the expected memory transfers and responses, plus a stall/reset sequence.
module tb_load_store_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        lsu_valid, lsu_ready, lsu_write, lsu_sign;
    logic [1:0]  lsu_size;
    logic [16:0] lsu_addr;
    logic [31:0] lsu_wdata;
    logic        lsu_done, lsu_err;
    logic [31:0] lsu_rdata;
    logic        mem_req, mem_we, mem_gnt, mem_rvalid;
    logic [16:0] mem_addr;
    logic [3:0]  mem_be;
    logic [31:0] mem_wdata, mem_rdata;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic        write;
        logic [1:0]  size;
        logic        sign;
        logic [16:0] addr;
        logic [31:0] wdata;
        int          nacc;
        logic [16:0] lo_addr;
        logic [3:0]  lo_be;
        logic [31:0] lo_wd;
        logic [31:0] lo_word;
        logic [16:0] hi_addr;
        logic [3:0]  hi_be;
        logic [31:0] hi_wd;
        logic [31:0] hi_word;
        logic [31:0] rdata;
        logic        err;
        int          lat;
    } vec_t;

    typedef struct {
        logic        we;
        logic [16:0] addr;
        logic [3:0]  be;
        logic [31:0] wdata;
        logic [31:0] rword;
    } mem_exp_t;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          lat;
        logic        chk_rd;
    } resp_exp_t;

    mem_exp_t  mem_q[$];
    resp_exp_t resp_q[$];
    vec_t      vecs[14];

    always #5 clk = ~clk;

    load_store_unit #(.ADDR_W(17)) dut (
        .clk        (clk),
        .rst        (rst),
        .lsu_valid  (lsu_valid),
        .lsu_ready  (lsu_ready),
        .lsu_write  (lsu_write),
        .lsu_size   (lsu_size),
        .lsu_sign   (lsu_sign),
        .lsu_addr   (lsu_addr),
        .lsu_wdata  (lsu_wdata),
        .lsu_done   (lsu_done),
        .lsu_err    (lsu_err),
        .lsu_rdata  (lsu_rdata),
        .mem_req    (mem_req),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_be     (mem_be),
        .mem_wdata  (mem_wdata),
        .mem_gnt    (mem_gnt),
        .mem_rvalid (mem_rvalid),
        .mem_rdata  (mem_rdata)
    );

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
        end
    endtask

    task automatic failNow(input string name);
        checks++;
        errors++;
        $display("[TB] FAIL %s: bound expired or scoreboard empty", name);
    endtask

    task automatic checkIdleOutputs(input string tag);
        checkOutput({tag, "_ready"}, 32'(lsu_ready), 32'd1);
        checkOutput({tag, "_done"},  32'(lsu_done),  32'd0);
        checkOutput({tag, "_err"},   32'(lsu_err),   32'd0);
        checkOutput({tag, "_rdata"}, lsu_rdata,      32'd0);
        checkOutput({tag, "_req"},   32'(mem_req),   32'd0);
        checkOutput({tag, "_we"},    32'(mem_we),    32'd0);
        checkOutput({tag, "_be"},    32'(mem_be),    32'd0);
        checkOutput({tag, "_addr"},  32'(mem_addr),  32'd0);
        checkOutput({tag, "_wdata"}, mem_wdata,      32'd0);
    endtask

    // Drives one request, plays an immediate-grant memory and scores transfers and response.
    task automatic applyStimulus(input int idx, input vec_t v);
        mem_exp_t  e;
        resp_exp_t r;
        int        cyc;
        bit        done_seen;
        bit        rd_pending;
        logic [31:0] rd_word;
        string     nm;
        nm = $sformatf("v%0d", idx);
        if (v.nacc > 0) mem_q.push_back('{v.write, v.lo_addr, v.lo_be, v.lo_wd, v.lo_word});
        if (v.nacc > 1) mem_q.push_back('{v.write, v.hi_addr, v.hi_be, v.hi_wd, v.hi_word});
        resp_q.push_back('{v.rdata, v.err, v.lat, (!v.write || v.err)});

        @(negedge clk);
        checkOutput({nm, "_ready_idle"}, 32'(lsu_ready), 32'd1);
        lsu_valid = 1'b1;
        lsu_write = v.write;
        lsu_size  = v.size;
        lsu_sign  = v.sign;
        lsu_addr  = v.addr;
        lsu_wdata = v.wdata;
        @(negedge clk);
        lsu_valid = 1'b0;
        cyc = 1;
        done_seen = 0;
        rd_pending = 0;
        rd_word = 32'h0;
        while (!done_seen && cyc <= 20) begin
            mem_gnt = 1'b0;
            mem_rvalid = 1'b0;
            if (rd_pending) begin
                mem_rvalid = 1'b1;
                mem_rdata = rd_word;
                rd_pending = 0;
            end
            if (mem_req) begin
                if (mem_q.size() == 0) begin
                    failNow({nm, "_extra_mem_req"});
                end else begin
                    e = mem_q.pop_front();
                    checkOutput({nm, "_mem_we"},   32'(mem_we),   32'(e.we));
                    checkOutput({nm, "_mem_addr"}, 32'(mem_addr), 32'(e.addr));
                    checkOutput({nm, "_mem_be"},   32'(mem_be),   32'(e.be));
                    if (e.we) checkOutput({nm, "_mem_wdata"}, mem_wdata, e.wdata);
                    mem_gnt = 1'b1;
                    if (!e.we) begin
                        rd_pending = 1;
                        rd_word = e.rword;
                    end
                end
            end
            if (lsu_done) begin
                done_seen = 1;
                if (resp_q.size() == 0) begin
                    failNow({nm, "_extra_done"});
                end else begin
                    r = resp_q.pop_front();
                    checkOutput({nm, "_latency"},    32'(cyc),       32'(r.lat));
                    checkOutput({nm, "_lsu_err"},    32'(lsu_err),   32'(r.err));
                    checkOutput({nm, "_ready_busy"}, 32'(lsu_ready), 32'd0);
                    if (r.chk_rd) checkOutput({nm, "_lsu_rdata"}, lsu_rdata, r.rdata);
                end
            end else begin
                @(negedge clk);
                cyc++;
            end
        end
        if (!done_seen) begin
            failNow({nm, "_done_timeout"});
            resp_q.delete();
        end
        @(negedge clk);
        mem_gnt = 1'b0;
        mem_rvalid = 1'b0;
        checkOutput({nm, "_done_pulse"},  32'(lsu_done),  32'd0);
        checkOutput({nm, "_ready_after"}, 32'(lsu_ready), 32'd1);
        checkOutput({nm, "_missing_acc"}, 32'(mem_q.size()), 32'd0);
        mem_q.delete();
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        rst = 1'b1;
        lsu_valid = 1'b0;
        lsu_write = 1'b0;
        lsu_size = 2'b00;
        lsu_sign = 1'b0;
        lsu_addr = 17'h0;
        lsu_wdata = 32'h0;
        mem_gnt = 1'b0;
        mem_rvalid = 1'b0;
        mem_rdata = 32'h0;

        // Fields: write size sign addr wdata nacc | lo addr be wd word | hi addr be wd word | rdata err lat
        vecs[0]  = '{1, 2'b00, 0, 17'h00100, 32'hDEADBEEF, 1, 17'h00100, 4'hF, 32'hDEADBEEF, 32'h0,
                     17'h0, 4'h0, 32'h0, 32'h0, 32'h0, 0, 2};
        vecs[1]  = '{0, 2'b10, 1, 17'h00103, 32'h0, 1, 17'h00100, 4'h8, 32'h0, 32'h80112233,
                     17'h0, 4'h0, 32'h0, 32'h0, 32'hFFFFFF80, 0, 3};
        vecs[2]  = '{0, 2'b10, 0, 17'h00103, 32'h0, 1, 17'h00100, 4'h8, 32'h0, 32'h80112233,
                     17'h0, 4'h0, 32'h0, 32'h0, 32'h00000080, 0, 3};
        vecs[3]  = '{0, 2'b00, 0, 17'h00102, 32'h0, 2, 17'h00100, 4'hC, 32'h0, 32'h44332211,
                     17'h00104, 4'h3, 32'h0, 32'h88776655, 32'h66554433, 0, 5};
        vecs[4]  = '{1, 2'b01, 0, 17'h1FFFF, 32'h0000ABCD, 2, 17'h1FFFC, 4'h8, 32'hCD000000, 32'h0,
                     17'h00000, 4'h1, 32'h000000AB, 32'h0, 32'h0, 0, 3};
        vecs[5]  = '{0, 2'b01, 1, 17'h00102, 32'h0, 1, 17'h00100, 4'hC, 32'h0, 32'h80011234,
                     17'h0, 4'h0, 32'h0, 32'h0, 32'hFFFF8001, 0, 3};
        vecs[6]  = '{0, 2'b01, 0, 17'h00101, 32'h0, 1, 17'h00100, 4'h6, 32'h0, 32'h00F0E0D0,
                     17'h0, 4'h0, 32'h0, 32'h0, 32'h0000F0E0, 0, 3};
        vecs[7]  = '{0, 2'b01, 1, 17'h00203, 32'h0, 2, 17'h00200, 4'h8, 32'h0, 32'hAA000000,
                     17'h00204, 4'h1, 32'h0, 32'h112233FE, 32'hFFFFFEAA, 0, 5};
        vecs[8]  = '{1, 2'b10, 0, 17'h00002, 32'h0000005A, 1, 17'h00000, 4'h4, 32'h005A0000, 32'h0,
                     17'h0, 4'h0, 32'h0, 32'h0, 32'h0, 0, 2};
        vecs[9]  = '{1, 2'b00, 0, 17'h1FFFE, 32'h11223344, 2, 17'h1FFFC, 4'hC, 32'h33440000, 32'h0,
                     17'h00000, 4'h3, 32'h00001122, 32'h0, 32'h0, 0, 3};
        vecs[10] = '{0, 2'b11, 0, 17'h00155, 32'h12345678, 0, 17'h0, 4'h0, 32'h0, 32'h0,
                     17'h0, 4'h0, 32'h0, 32'h0, 32'h0, 1, 1};
        vecs[11] = '{1, 2'b11, 1, 17'h00155, 32'h12345678, 0, 17'h0, 4'h0, 32'h0, 32'h0,
                     17'h0, 4'h0, 32'h0, 32'h0, 32'h0, 1, 1};
        vecs[12] = '{0, 2'b00, 0, 17'h1FFFC, 32'h0, 1, 17'h1FFFC, 4'hF, 32'h0, 32'hCAFEF00D,
                     17'h0, 4'h0, 32'h0, 32'h0, 32'hCAFEF00D, 0, 3};
        vecs[13] = '{0, 2'b10, 0, 17'h1FFFD, 32'h0, 1, 17'h1FFFC, 4'h2, 32'h0, 32'h12345678,
                     17'h0, 4'h0, 32'h0, 32'h0, 32'h00000056, 0, 3};

        repeat (2) @(negedge clk);
        checkIdleOutputs("reset");
        rst = 1'b0;

        for (int i = 0; i < 14; i++) begin
            applyStimulus(i, vecs[i]);
        end

        // Grant withheld for several cycles, then reset while waiting for read data.
        @(negedge clk);
        lsu_valid = 1'b1;
        lsu_write = 1'b0;
        lsu_size  = 2'b00;
        lsu_sign  = 1'b0;
        lsu_addr  = 17'h00100;
        lsu_wdata = 32'h0;
        @(negedge clk);
        lsu_valid = 1'b0;
        lsu_addr  = 17'h0AAA8;
        for (int i = 0; i < 5; i++) begin
            checkOutput("stall_req",  32'(mem_req),  32'd1);
            checkOutput("stall_we",   32'(mem_we),   32'd0);
            checkOutput("stall_addr", 32'(mem_addr), 32'h00100);
            checkOutput("stall_be",   32'(mem_be),   32'hF);
            checkOutput("stall_done", 32'(lsu_done), 32'd0);
            @(negedge clk);
        end
        checkOutput("stall_req_hold", 32'(mem_req), 32'd1);
        mem_gnt = 1'b1;
        @(negedge clk);
        mem_gnt = 1'b0;
        checkOutput("wait_lo_req", 32'(mem_req), 32'd0);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checkIdleOutputs("midreset");
        mem_rvalid = 1'b1;
        mem_rdata  = 32'h12345678;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checkOutput("late_rvalid_done",  32'(lsu_done),  32'd0);
            checkOutput("late_rvalid_ready", 32'(lsu_ready), 32'd1);
            checkOutput("late_rvalid_req",   32'(mem_req),   32'd0);
        end
        mem_rvalid = 1'b0;

        applyStimulus(100, vecs[3]);
        applyStimulus(101, vecs[4]);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
